// File: rtl/id_digit_collector_pkg.sv
// Shared constants and FSM encoding for the ID digit collector.
package id_digit_collector_pkg;

  localparam int unsigned ID_NUM_DIGITS = 9;
  localparam int unsigned ID_DIGIT_W    = 4;
  localparam int unsigned IDX_W         = 4;
  localparam int unsigned LAST_STATE    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/id_slot_file.sv
// Digit register file with valid mask, mask clear, one write port and a combinational read port.
module id_slot_file
  import id_digit_collector_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = ID_NUM_DIGITS,
  parameter int unsigned DIGIT_W    = ID_DIGIT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DIGIT_W-1:0]    wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DIGIT_W-1:0]    rd_data,
  output logic [NUM_DIGITS-1:0] valid,
  output logic [IDX_W-1:0]      count
);

  logic [DIGIT_W-1:0]    slots [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] valid_next;
  logic [IDX_W-1:0]      count_next;
  logic                  wr_ok;

  assign wr_ok = wr_en && (32'(wr_idx) < NUM_DIGITS);

  // Clear drops the whole mask before the same-cycle write re-marks its slot.
  always_comb begin
    valid_next = clr ? '0 : valid;
    if (wr_ok) valid_next[wr_idx] = 1'b1;
    count_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      count_next = count_next + IDX_W'(valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) slots[i] <= '0;
      valid <= '0;
      count <= '0;
    end else begin
      if (wr_ok) slots[wr_idx] <= wr_data;
      valid <= valid_next;
      count <= count_next;
    end
  end

  always_comb begin
    rd_data = '0;
    if ((32'(rd_idx) < NUM_DIGITS) && valid[rd_idx]) rd_data = slots[rd_idx];
  end

endmodule

// File: rtl/id_digit_collector.sv
// Captures the per-state digits of an upstream 0..8 Mealy counter and flags completion or sequencing errors.
module id_digit_collector
  import id_digit_collector_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = ID_NUM_DIGITS,
  parameter int unsigned DIGIT_W    = ID_DIGIT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_in,
  input  logic [DIGIT_W-1:0]    student_id,
  input  logic [IDX_W-1:0]      currentstate,
  input  logic [IDX_W-1:0]      rd_sel,
  output logic [DIGIT_W-1:0]    rd_digit,
  output logic [NUM_DIGITS-1:0] valid_mask,
  output logic [IDX_W-1:0]      digit_count,
  output logic                  advance_pulse,
  output logic                  id_complete,
  output logic                  seq_error
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_STATE);

  state_t           state, state_next;
  logic [IDX_W-1:0] prev_state;
  logic             wr_en, clr, adv_next;
  logic             in_range, same_state, step_up, at_zero, capture, fills_last;

  assign in_range   = currentstate <= LAST_IDX;
  assign same_state = currentstate == prev_state;
  assign step_up    = currentstate == (prev_state + IDX_W'(1));
  assign at_zero    = currentstate == '0;
  assign capture    = !data_in;
  assign fills_last = (currentstate == LAST_IDX) && (&valid_mask[NUM_DIGITS-2:0]);

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    clr        = 1'b0;
    adv_next   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (at_zero && capture) begin
          wr_en      = 1'b1;
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (!in_range) begin
          state_next = ST_ERROR;
        end else if (same_state || step_up) begin
          adv_next = step_up;
          wr_en    = capture;
          if (capture && fills_last) state_next = ST_DONE;
        end else if (at_zero) begin
          // Upstream counter restarted: begin a fresh ID, not an error.
          clr   = 1'b1;
          wr_en = capture;
        end else begin
          state_next = ST_ERROR;
        end
      end
      ST_DONE: begin
        if (same_state) begin
          state_next = ST_DONE;
        end else if (at_zero && (prev_state == LAST_IDX)) begin
          adv_next   = 1'b1;
          clr        = 1'b1;
          wr_en      = capture;
          state_next = ST_COLLECT;
        end else begin
          state_next = ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (at_zero && capture) begin
          clr        = 1'b1;
          wr_en      = 1'b1;
          state_next = ST_COLLECT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      prev_state    <= '0;
      advance_pulse <= 1'b0;
      id_complete   <= 1'b0;
      seq_error     <= 1'b0;
    end else begin
      state         <= state_next;
      prev_state    <= currentstate;
      advance_pulse <= adv_next;
      id_complete   <= state_next == ST_DONE;
      seq_error     <= state_next == ST_ERROR;
    end
  end

  id_slot_file #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_slots (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_idx  (currentstate),
    .wr_data (student_id),
    .rd_idx  (rd_sel),
    .rd_data (rd_digit),
    .valid   (valid_mask),
    .count   (digit_count)
  );

endmodule

// File: doc/id_digit_collector.md
ID_DIGIT_COLLECTOR -- requirements
Module: id_digit_collector

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter NUM_DIGITS, default 9, SHALL be the number of ID digit slots, one per counter state s0..s8.
REQ-003 Parameter DIGIT_W, default 4, SHALL be the width of each digit.
REQ-004 clk  input  1  rising-edge clock, shared with the upstream 0-to-8 Mealy counter.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 data_in  input  1  the same advance request the counter receives.
REQ-007 student_id  input  4  counter Mealy digit output.
REQ-008 currentstate  input  4  counter present state, 0..8.
REQ-009 rd_sel  input  4  read slot index.
REQ-010 rd_digit  output  4  combinational read of slot rd_sel.
REQ-011 valid_mask  output  9  bit k set when slot k holds a captured digit.
REQ-012 digit_count  output  4  population count of valid_mask.
REQ-013 advance_pulse  output  1  one-cycle pulse on a legal state advance.
REQ-014 id_complete  output  1  high while all 9 slots are valid in DONE.
REQ-015 seq_error  output  1  high while in ERROR.

Function
REQ-016 The block SHALL capture only when data_in==0, so that student_id is the digit of the present state: slot[currentstate] <= student_id, valid_mask[currentstate] <= 1.
REQ-017 The block SHALL register currentstate into prev_state every cycle.
REQ-018 FSM states SHALL be IDLE, COLLECT, DONE and ERROR.
REQ-019 IDLE: on currentstate==0 with data_in==0, the block SHALL capture slot 0 and go to COLLECT next cycle; all other inputs SHALL be ignored.
REQ-020 COLLECT, legal advance: when currentstate==prev_state+1, the block SHALL assert advance_pulse for that one cycle.
REQ-021 COLLECT, restart: when currentstate==0 and prev_state!=0 (upstream reset), the block SHALL clear valid_mask and capture slot 0 only if data_in==0; this SHALL NOT be an error.
REQ-022 COLLECT, illegal change: a skip, a backward step to nonzero, or currentstate>8 SHALL send the block to ERROR next cycle with no capture.
REQ-023 COLLECT to DONE: the block SHALL enter DONE on the cycle after slot 8 is captured with all 9 mask bits set.
REQ-024 DONE SHALL assert id_complete; slots SHALL hold.
REQ-025 DONE, wrap: currentstate==0 after prev_state==8 SHALL pulse advance_pulse, clear valid_mask, capture slot 0 if data_in==0 and go to COLLECT.
REQ-026 DONE, any other change of currentstate SHALL go to ERROR.
REQ-027 ERROR: on currentstate==0 with data_in==0, the block SHALL clear valid_mask, capture slot 0 and go to COLLECT.
REQ-028 A repeated capture in an unchanged state SHALL overwrite the same slot and SHALL NOT change digit_count.
REQ-029 rd_digit SHALL equal slot[rd_sel] when rd_sel<=8 and that slot is valid; otherwise it SHALL be 0.
REQ-030 digit_count SHALL range 0..9 with no wrap.

Reset
REQ-031 Reset SHALL dominate every simultaneous event.
REQ-032 Reset SHALL set FSM=IDLE, prev_state=0, all slots=0, valid_mask=0, digit_count=0, and advance_pulse=id_complete=seq_error=0.
REQ-033 After reset, rd_digit SHALL be 0; reset mid-COLLECT SHALL discard all captured digits.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, NUM_DIGITS, DIGIT_W and LAST_STATE=8.
REQ-035 The implementation SHALL use one sub-module, id_slot_file: a 9x4 register file with valid mask, clear, write port and combinational read port.

Verification
REQ-036 Reset, then inputs stepping s0..s8 with data_in low one cycle per state, digits 8,5,0,1,1,7,0,1,3 -> id_complete=1, valid_mask=0x1FF, digit_count=9, and rd_sel=5 reads 7.
REQ-037 In COLLECT at state 3, currentstate jumps to 5 -> seq_error=1 next cycle, valid_mask unchanged, no advance_pulse.
REQ-038 In DONE, currentstate 8->0 with student_id=8 and data_in=0 -> advance_pulse=1, valid_mask=0x001, FSM=COLLECT.
REQ-039 In COLLECT at state 4, currentstate drops to 0 (upstream reset) -> seq_error=0, valid_mask=0x001.
REQ-040 reset asserted in the same cycle as the slot-8 capture -> id_complete=0, valid_mask=0, and rd_sel=8 reads 0.
REQ-041 data_in held high across an advance -> no capture in that cycle; rd_sel=9 reads 0.
